vector_uncons: RTL and testbench
================================

VECTOR_UNCONS -- requirements
Module: vector_uncons

Interface
REQ-001 Parameter VEC_BYTES, default 16, number of bytes per input vector.
REQ-002 Parameter LEN_W, default 5, width of the length field (clog2(VEC_BYTES)+1).
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  in_data/in_len valid.
REQ-006 in_ready  output  1  block accepts a vector this cycle.
REQ-007 in_data  input  8*VEC_BYTES  vector; head byte in in_data[MSB-:8], followed by the next byte down.
REQ-008 in_len  input  LEN_W  number of bytes to emit, counted from the head; legal 1..VEC_BYTES.
REQ-009 out_valid  output  1  out_byte is valid.
REQ-010 out_ready  input  1  sink accepts out_byte.
REQ-011 out_byte  output  8  current head byte.
REQ-012 out_last  output  1  out_byte is the final byte of the current vector.
REQ-013 len_err  output  1  one-cycle pulse when a vector with an illegal in_len is accepted.
REQ-014 vec_count  output  32  count of vectors fully emitted; wraps modulo 2^32.

Function
REQ-015 The block is the inverse of the vector-cons datapath: it repeatedly takes the head byte of a held vector and retains the tail, one byte per out handshake.
REQ-016 An input handshake occurs when in_valid && in_ready at posedge clk; an output handshake occurs when out_valid && out_ready at posedge clk.
REQ-017 State is two states. IDLE has remaining count 0. EMIT has remaining count 1..VEC_BYTES.
REQ-018 in_ready = !rst && (count==0 || (count==1 && out_ready)), so the next vector loads in the same cycle the last byte drains (zero-bubble back-to-back).
REQ-019 On an input handshake with a legal in_len: hold <= in_data, count <= in_len, next state EMIT.
REQ-020 First-byte latency is 1 cycle: out_valid is high in the cycle after acceptance.
REQ-021 out_valid = (count != 0); out_byte = hold[MSB-:8]; out_last = (count == 1).
REQ-022 On an output handshake with count > 1: hold <= hold << 8 (zero fill), count <= count - 1.
REQ-023 On an output handshake with count == 1 and no simultaneous input handshake: count <= 0, next state IDLE.
REQ-024 On an output handshake with count == 1 together with an input handshake: the load of REQ-019 takes priority over the shift.
REQ-025 vec_count increments by exactly 1 on every output handshake with out_last = 1.
REQ-026 While out_valid && !out_ready, out_byte and out_last shall hold stable, and in_ready = 0 unless the REQ-018 condition holds.
REQ-027 in_len == 0 or in_len > VEC_BYTES is illegal. Such a vector is accepted and discarded, count stays 0, and len_err pulses for exactly the cycle after acceptance.
REQ-028 If an illegal vector is accepted under the drain condition of REQ-018, it is still discarded and the block goes to IDLE.
REQ-029 Data beyond in_len bytes is never emitted.

Reset
REQ-030 While rst is high: count=0, hold=0, vec_count=0, len_err=0, out_valid=0, out_last=0, out_byte=0, in_ready=0.
REQ-031 Reset asserted mid-vector abandons the remaining bytes and does not increment vec_count.
REQ-032 The first handshake after reset is possible on the first posedge clk with rst low.

Structure
REQ-033 A shared package vector_uncons_pkg holds VEC_BYTES, LEN_W, the vec_t (8*VEC_BYTES-bit) typedef and the len_t typedef.
REQ-034 One sub-module, uncons_hold, contains the hold register, the shift and the remaining-count logic. The top level contains the handshake logic, len_err and vec_count.
REQ-035 The design is fully synchronous to clk apart from the asynchronous rst; it has no combinational path from in_data to out_byte.

Verification
REQ-036 Single vector: in_data=0x00112233_44556677_8899AABB_CCDDEEFF, in_len=16, out_ready=1 -> bytes 00,11,...,FF on 16 consecutive cycles, out_last only on FF, vec_count=1.
REQ-037 Back-to-back: two vectors of in_len=4, heads DEADBEEF.. and CAFEF00D.. -> 8 bytes DE AD BE EF CA FE F0 0D with no bubble, out_last on EF and 0D, vec_count=2.
REQ-038 Backpressure: out_ready toggles 1,0,0,1 on an in_len=3 vector A1B2C3.. -> each byte is held stable while stalled, and the order A1,B2,C3 is preserved.
REQ-039 Illegal length: in_len=0, then in_len=17 -> both vectors accepted, len_err pulses once for each, no out_valid, vec_count unchanged.
REQ-040 Reset mid-operation: rst asserted after 5 of 16 bytes -> out_valid=0 at once, and vec_count=0 after release.
REQ-041 Wrap: vec_count preloaded to 0xFFFFFFFF by force, one in_len=1 vector completes -> vec_count=0.

Source files
------------

// File: rtl/vector_uncons_pkg.sv
// Shared sizing, types and state encoding for the
// vector unconser datapath.
package vector_uncons_pkg;

  localparam int VEC_BYTES = 16;
  localparam int LEN_W     = 5;

  typedef logic [8*VEC_BYTES-1:0] vec_t;
  typedef logic [LEN_W-1:0]       len_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

endpackage

// File: rtl/vector_uncons_hold.sv
// Hold register for the vector being unconsed: load,
// head-byte shift and remaining-byte count.
module uncons_hold #(
  parameter int VEC_BYTES = 16,
  parameter int LEN_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [8*VEC_BYTES-1:0] load_data,
  input  logic [LEN_W-1:0]       load_len,
  input  logic                   shift,
  output logic [7:0]             head,
  output logic [LEN_W-1:0]       count,
  output logic [0:0]             state
);
  import vector_uncons_pkg::*;

  localparam int VW = 8 * VEC_BYTES;

  logic [VW-1:0]    hold_q, hold_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             more;

  assign more = cnt_q > LEN_W'(1);

  // A load always wins over a shift of the final byte.
  always_comb begin
    hold_d = hold_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      load: begin
        hold_d = load_data;
        cnt_d  = load_len;
      end
      (!load && shift && more): begin
        hold_d = {hold_q[VW-9:0], 8'h00};
        cnt_d  = cnt_q - LEN_W'(1);
      end
      (!load && shift && !more): begin
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head  = hold_q[VW-1 -: 8];
  assign count = cnt_q;
  assign state = (cnt_q == '0) ? ST_IDLE : ST_EMIT;

endmodule

// File: rtl/vector_uncons.sv
// Vector unconser: emits the held vector head-first, one byte
// per out handshake, with zero-bubble reload on the last byte.
module vector_uncons #(
  parameter int VEC_BYTES = 16,
  parameter int LEN_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*VEC_BYTES-1:0] in_data,
  input  logic [LEN_W-1:0]       in_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   out_last,
  output logic                   len_err,
  output logic [31:0]            vec_count
);
  import vector_uncons_pkg::*;

  logic             in_hs, out_hs;
  logic             len_ok, last;
  logic [LEN_W-1:0] count;
  logic [0:0]       state;
  logic [7:0]       head;

  logic        len_err_q, len_err_d;
  logic [31:0] vec_cnt_q, vec_cnt_d;

  uncons_hold #(
    .VEC_BYTES(VEC_BYTES),
    .LEN_W    (LEN_W)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (in_hs && len_ok),
    .load_data(in_data),
    .load_len (in_len),
    .shift    (out_hs),
    .head     (head),
    .count    (count),
    .state    (state)
  );

  assign last      = count == LEN_W'(1);
  assign out_valid = state == ST_EMIT;
  assign out_byte  = head;
  assign out_last  = last;

  assign in_ready = !rst &&
    (!out_valid || (last && out_ready));

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign len_ok = (in_len != '0) &&
    (in_len <= LEN_W'(VEC_BYTES));

  always_comb begin
    len_err_d = in_hs && !len_ok;
    vec_cnt_d = vec_cnt_q;
    if (out_hs && last)
      vec_cnt_d = vec_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_err_q <= 1'b0;
      vec_cnt_q <= '0;
    end else begin
      len_err_q <= len_err_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

  assign len_err   = len_err_q;
  assign vec_count = vec_cnt_q;

endmodule

// File: tb/tb_vector_uncons.sv
// Scoreboard bench for vector_uncons: directed vectors push
// expected bytes, a negedge monitor pops and compares.
module tb_vector_uncons;
  import vector_uncons_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  vec_t        in_data = '0;
  len_t        in_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        len_err;
  logic [31:0] vec_count;

  int n_cmp = 0;
  int n_bad = 0;
  int popped = 0;
  int err_pulses = 0;
  int cyc = 0;
  int pop_cyc[$];
  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic       stall_p = 1'b0;
  logic [7:0] stall_b;
  logic       stall_l;

  vector_uncons dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_len   (in_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .out_last (out_last),
    .len_err  (len_err),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: output handshakes, stall stability, len_err pulses.
  always @(negedge clk) begin
    cyc++;
    if (len_err === 1'b1) err_pulses++;
    if (stall_p && !rst) begin
      check("stall_byte", {24'h0, out_byte}, {24'h0, stall_b});
      check("stall_last", {31'h0, out_last}, {31'h0, stall_l});
    end
    stall_p = out_valid && !out_ready;
    stall_b = out_byte;
    stall_l = out_last;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %0h want none", out_byte);
      end else begin
        e = exp_q.pop_front();
        check("out_byte", {24'h0, out_byte}, {24'h0, e[7:0]});
        check("out_last", {31'h0, out_last}, {31'h0, e[8]});
        popped++;
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input vec_t d, input int len,
                      input bit legal);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = len_t'(len);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL in_ready_timeout: got 0 want 1");
        break;
      end
    end
    if (legal)
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1),
                         d[8*VEC_BYTES-1-8*i -: 8]});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_len   = '0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d left want 0",
               exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  localparam vec_t V16 =
    128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    int mark, e0, t;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_last", {31'h0, out_last}, 32'h0);
    check("rst_out_byte", {24'h0, out_byte}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_len_err", {31'h0, len_err}, 32'h0);
    check("rst_vec_count", vec_count, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Single full-length vector
    send(V16, 16, 1'b1);
    wait_drain();
    check("single_vec_count", vec_count, 32'd1);

    // Back-to-back, garbage beyond in_len must not appear
    pop_cyc.delete();
    send(128'hDEADBEEF_12345678_9ABCDEF0_13579BDF, 4, 1'b1);
    send(128'hCAFEF00D_FFFFFFFF_EEEEEEEE_DDDDDDDD, 4, 1'b1);
    wait_drain();
    if (pop_cyc.size() >= 8)
      check("b2b_span", pop_cyc[7] - pop_cyc[0], 32'd7);
    else
      check("b2b_pops", pop_cyc.size(), 32'd8);
    check("b2b_vec_count", vec_count, 32'd3);

    // Backpressure 1,0,0,1
    out_ready = 1'b0;
    send(128'hA1B2C3FF_00000000_00000000_00000000, 3, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
    check("bp_vec_count", vec_count, 32'd4);

    // Illegal lengths 0 and 17
    e0 = err_pulses;
    send(V16, 0, 1'b0);
    send(V16, 17, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("illegal_err_pulses", err_pulses - e0, 32'd2);
    check("illegal_out_valid", {31'h0, out_valid}, 32'h0);
    check("illegal_len_err_low", {31'h0, len_err}, 32'h0);
    check("illegal_vec_count", vec_count, 32'd4);

    // Illegal vector accepted while last byte drains
    e0 = err_pulses;
    send(128'h5A000000_00000000_00000000_00000000, 1, 1'b1);
    send(V16, 0, 1'b0);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("drain_err_pulses", err_pulses - e0, 32'd1);
    check("drain_out_valid", {31'h0, out_valid}, 32'h0);
    check("drain_vec_count", vec_count, 32'd5);

    // Reset after 5 of 16 bytes
    mark = popped;
    send(V16, 16, 1'b1);
    t = 0;
    while (popped < mark + 5 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_progress", popped - mark, 32'd5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_mid_in_ready", {31'h0, in_ready}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_vec_count", vec_count, 32'h0);
    check("rst_mid_valid_after", {31'h0, out_valid}, 32'h0);

    // vec_count wrap
    force dut.vec_cnt_q = 32'hFFFF_FFFF;
    #2;
    release dut.vec_cnt_q;
    send(128'h77000000_00000000_00000000_00000000, 1, 1'b1);
    wait_drain();
    check("wrap_vec_count", vec_count, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
